// File: rtl/multi_channel_memory.sv
// Shared data memory for several requesters.
// Round-robin arbitration over one storage port.
module multi_channel_memory #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 256,
  parameter int NUM_CHANNELS = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]           mem_read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_ready
);

  localparam int N  = NUM_CHANNELS;
  localparam int L  = READ_LATENCY;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state [N];
  logic [CW-1:0]        rr;
  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [N-1:0]         req;
  logic [N-1:0]         gnt_oh;
  logic                 gnt_v;
  logic                 gnt_wr;
  logic [CW-1:0]        gnt;
  logic [ADDR_BITS-1:0] gnt_addr;
  logic [DATA_BITS-1:0] gnt_wdata;
  logic                 in_range;
  logic [IW-1:0]        idx;

  logic [N-1:0]         wr_q;
  logic [N-1:0]         ph [L];
  logic [DATA_BITS-1:0] pd [L];
  logic [DATA_BITS-1:0] rd_q [N];

  always_comb begin
    int j;
    j      = 0;
    gnt_v  = 1'b0;
    gnt    = '0;
    req    = '0;
    gnt_oh = '0;
    for (int c = 0; c < N; c++)
      req[c] = (state[c] == IDLE) &&
               (mem_read_valid[c] || mem_write_valid[c]);
    for (int i = 0; i < N; i++) begin
      j = (int'(rr) + i) % N;
      if (!gnt_v && req[j]) begin
        gnt_v = 1'b1;
        gnt   = CW'(j);
      end
    end
    for (int c = 0; c < N; c++)
      gnt_oh[c] = gnt_v && (gnt == CW'(c));
    // write wins when a channel presents both
    gnt_wr    = gnt_v && mem_write_valid[gnt];
    gnt_addr  = gnt_wr ? mem_write_address[gnt*ADDR_BITS +: ADDR_BITS]
                       : mem_read_address[gnt*ADDR_BITS +: ADDR_BITS];
    gnt_wdata = mem_write_data[gnt*DATA_BITS +: DATA_BITS];
    in_range  = 32'(gnt_addr) < 32'(DEPTH);
    idx       = gnt_addr[IW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr <= '0;
      for (int c = 0; c < N; c++)
        state[c] <= IDLE;
    end else begin
      if (gnt_v)
        rr <= (gnt == CW'(N-1)) ? '0 : gnt + 1'b1;
      for (int c = 0; c < N; c++) begin
        unique case (state[c])
          IDLE: if (gnt_oh[c]) state[c] <= BUSY;
          BUSY: if (mem_write_ready[c] || mem_read_ready[c])
                  state[c] <= DONE;
          DONE: if (!mem_read_valid[c] && !mem_write_valid[c])
                  state[c] <= IDLE;
          default: state[c] <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_wr && in_range)
      mem[idx] <= gnt_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      for (int k = 0; k < L; k++) begin
        ph[k] <= '0;
        pd[k] <= '0;
      end
      for (int c = 0; c < N; c++)
        rd_q[c] <= '0;
    end else begin
      wr_q  <= gnt_wr ? gnt_oh : '0;
      ph[0] <= gnt_wr ? '0 : gnt_oh;
      pd[0] <= in_range ? mem[idx] : '0;
      for (int k = 1; k < L; k++) begin
        ph[k] <= ph[k-1];
        pd[k] <= pd[k-1];
      end
      for (int c = 0; c < N; c++)
        if (ph[L-1][c])
          rd_q[c] <= pd[L-1];
    end
  end

  always_comb begin
    mem_read_data   = '0;
    mem_write_ready = wr_q;
    mem_read_ready  = ph[L-1];
    for (int c = 0; c < N; c++)
      mem_read_data[c*DATA_BITS +: DATA_BITS] =
        ph[L-1][c] ? pd[L-1] : rd_q[c];
  end

endmodule
